// File: rtl/ma_channel_scheduler.sv
// Sequences one shared mean-amplitude extractor across all channels of a window
// and hands the packed per-channel MA levels to the encoder over valid/ready.
module ma_channel_scheduler #(
    parameter int NUM_CHS = 17,
    parameter int NUM_MA  = 64,
    parameter int TIMEOUT = 512
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              start,
    output logic                              ext_en,
    output logic [$clog2(NUM_CHS)-1:0]        ext_ch,
    input  logic                              ext_done,
    input  logic [$clog2(NUM_MA)-1:0]         ext_ma,
    output logic [NUM_CHS*$clog2(NUM_MA)-1:0] ma_vec,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              overrun,
    output logic                              timeout_err,
    input  logic                              clr_err
);

    localparam int MA_W  = $clog2(NUM_MA);
    localparam int CH_W  = $clog2(NUM_CHS);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               tmo_hit;
    logic               last_ch;
    logic               ch_end;

    assign tmo_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign last_ch = (ext_ch == CH_W'(NUM_CHS - 1));
    assign ch_end  = (state == WAIT) && (ext_done || tmo_hit);

    // NOTE: next_state defaults to state before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LAUNCH;
            LAUNCH:  next_state = WAIT;
            WAIT:    if (ext_done || tmo_hit) next_state = last_ch ? DONE : LAUNCH;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            ext_ch      <= '0;
            ext_en      <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            ma_vec      <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state     <= next_state;
            ext_en    <= (next_state == LAUNCH);
            out_valid <= (next_state == DONE);
            busy      <= (next_state != IDLE);

            case (state)
                IDLE: begin
                    if (start) ext_ch <= '0;
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    for (int c = 0; c < NUM_CHS; c++) begin
                        if (ext_ch == CH_W'(c)) begin
                            if (ext_done)     ma_vec[c*MA_W +: MA_W] <= ext_ma;
                            else if (tmo_hit) ma_vec[c*MA_W +: MA_W] <= '0;
                        end
                    end
                    if (ch_end && !last_ch) ext_ch <= ext_ch + CH_W'(1);
                end
                default: ;
            endcase

            // Sticky flags: a set event in the same cycle as clr_err takes priority.
            if (start && state != IDLE) overrun <= 1'b1;
            else if (clr_err)           overrun <= 1'b0;

            if (state == WAIT && !ext_done && tmo_hit) timeout_err <= 1'b1;
            else if (clr_err)                          timeout_err <= 1'b0;
        end
    end

endmodule
